// File: rtl/dec_exe_alu_pkg.sv
// Shared decode constants, ALU operation enumeration and decoded-control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dec_exe_alu_pkg;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, inst[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_NOR = 3'b111
    } alu_op_e;

    // Decoder output; ovf_en marks the trapping arithmetic forms
    // (add, addi, sub, beq) whose signed overflow is reported.
    typedef struct packed {
        logic    regdst;
        logic    regwr;
        logic    extop;
        logic    alusrc;
        logic    memwr;
        logic    memtoreg;
        logic    jump;
        logic    branch;
        alu_op_e op;
        logic    ovf_en;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/dec_exe_alu_if.sv
// Bundle of instruction/operand inputs and registered decode/execute outputs.
// Latency: n/a (signal grouping only).
// Backpressure: none; the block accepts a new instruction every cycle.
// Ports: inst, rs_val, rt_val in; control flags, signal, register fields,
// offsets, imm, alu_result, zero, overflow, illegal out.
interface dec_exe_alu_if;
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    logic        regdst;
    logic        regwr;
    logic        extop;
    logic        alusrc;
    logic        memwr;
    logic        memtoreg;
    logic        jump;
    logic        branch;
    logic [2:0]  signal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] beq_offset;
    logic [25:0] jump_offset;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    // Instruction source side
    modport master (
        output inst, rs_val, rt_val,
        input  regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch,
        input  signal, rs, rt, rd, beq_offset, jump_offset, imm,
        input  alu_result, zero, overflow, illegal
    );

    // Decode/execute block side
    modport slave (
        input  inst, rs_val, rt_val,
        output regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch,
        output signal, rs, rt, rd, beq_offset, jump_offset, imm,
        output alu_result, zero, overflow, illegal
    );
endinterface

// File: rtl/dec_exe_alu_alu_core.sv
// Combinational 32-bit ALU: add/sub/and/or/slt/sll/srl/nor with signed-overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b operands; shamt shift amount; op operation; result, zero, overflow out.
module alu_core
    import dec_exe_alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum;
                // Same-sign operands producing an opposite-sign sum
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff;
                // Differing-sign operands where the result flips away from a
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_NOR: result = ~(a | b);
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/dec_exe_alu.sv
// MIPS-subset decode + execute stage: decodes inst, runs the ALU, registers everything.
// Latency: 1 cycle from inst/rs_val/rt_val to all outputs.
// Backpressure: none; a new instruction is taken on every rising clk edge.
// Ports: clk, rst (sync active-high); bus (slave) carries inst/operands in, decoded controls and ALU results out.
module dec_exe_alu
    import dec_exe_alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dec_exe_alu_if.slave bus
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt;
    ctrl_t       ctrl;
    logic        regwr_eff;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [31:0] core_result;
    logic        core_zero;
    logic        core_ovf;
    logic [31:0] result_nxt;
    logic        zero_nxt;
    logic        ovf_nxt;

    assign opcode = bus.inst[31:26];
    assign rs_f   = bus.inst[25:21];
    assign rt_f   = bus.inst[20:16];
    assign rd_f   = bus.inst[15:11];
    assign shamt  = bus.inst[10:6];
    assign funct  = bus.inst[5:0];

    // Main decoder
    always_comb begin
        ctrl    = '0;
        ctrl.op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst = 1'b1;
                ctrl.regwr  = 1'b1;
                case (funct)
                    FN_ADD:  begin ctrl.op = ALU_ADD; ctrl.ovf_en = 1'b1; end
                    FN_ADDU: ctrl.op = ALU_ADD;
                    FN_SUB:  begin ctrl.op = ALU_SUB; ctrl.ovf_en = 1'b1; end
                    FN_SUBU: ctrl.op = ALU_SUB;
                    FN_AND:  ctrl.op = ALU_AND;
                    FN_OR:   ctrl.op = ALU_OR;
                    FN_NOR:  ctrl.op = ALU_NOR;
                    FN_SLT:  ctrl.op = ALU_SLT;
                    FN_SLL:  ctrl.op = ALU_SLL;
                    FN_SRL:  ctrl.op = ALU_SRL;
                    default: begin
                        ctrl         = '0;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl.regwr  = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.extop  = 1'b1;
                ctrl.ovf_en = 1'b1;
            end
            OP_ANDI: begin
                ctrl.regwr  = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.op     = ALU_AND;
            end
            OP_ORI: begin
                ctrl.regwr  = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.op     = ALU_OR;
            end
            OP_LW: begin
                ctrl.regwr    = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.extop    = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl.memwr  = 1'b1;
                ctrl.alusrc = 1'b1;
                ctrl.extop  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.extop  = 1'b1;
                ctrl.op     = ALU_SUB;
                ctrl.ovf_en = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Writes to $zero are squashed so downstream never sees a live write to r0
    assign regwr_eff = ctrl.regwr && ((ctrl.regdst ? rd_f : rt_f) != 5'd0);

    assign imm_ext = ctrl.extop ? {{16{bus.inst[15]}}, bus.inst[15:0]}
                                : {16'd0, bus.inst[15:0]};
    assign alu_b   = ctrl.alusrc ? imm_ext : bus.rt_val;

    alu_core u_alu_core (
        .a        (bus.rs_val),
        .b        (alu_b),
        .shamt    (shamt),
        .op       (ctrl.op),
        .result   (core_result),
        .zero     (core_zero),
        .overflow (core_ovf)
    );

    // Illegal instructions report a zero result, so zero tracks that
    assign result_nxt = ctrl.illegal ? 32'd0 : core_result;
    assign zero_nxt   = ctrl.illegal ? 1'b1  : core_zero;
    assign ovf_nxt    = ctrl.ovf_en & core_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.regdst      <= 1'b0;
            bus.regwr       <= 1'b0;
            bus.extop       <= 1'b0;
            bus.alusrc      <= 1'b0;
            bus.memwr       <= 1'b0;
            bus.memtoreg    <= 1'b0;
            bus.jump        <= 1'b0;
            bus.branch      <= 1'b0;
            bus.signal      <= 3'd0;
            bus.rs          <= 5'd0;
            bus.rt          <= 5'd0;
            bus.rd          <= 5'd0;
            bus.beq_offset  <= 16'd0;
            bus.jump_offset <= 26'd0;
            bus.imm         <= 32'd0;
            bus.alu_result  <= 32'd0;
            bus.zero        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.illegal     <= 1'b0;
        end else begin
            bus.regdst      <= ctrl.regdst;
            bus.regwr       <= regwr_eff;
            bus.extop       <= ctrl.extop;
            bus.alusrc      <= ctrl.alusrc;
            bus.memwr       <= ctrl.memwr;
            bus.memtoreg    <= ctrl.memtoreg;
            bus.jump        <= ctrl.jump;
            bus.branch      <= ctrl.branch;
            bus.signal      <= ctrl.op;
            bus.rs          <= rs_f;
            bus.rt          <= rt_f;
            bus.rd          <= rd_f;
            bus.beq_offset  <= bus.inst[15:0];
            bus.jump_offset <= bus.inst[25:0];
            bus.imm         <= imm_ext;
            bus.alu_result  <= result_nxt;
            bus.zero        <= zero_nxt;
            bus.overflow    <= ovf_nxt;
            bus.illegal     <= ctrl.illegal;
        end
    end

endmodule

// File: tb/tb_dec_exe_alu.sv
// Testbench for dec_exe_alu: directed vectors plus randomized instructions,
// scoreboarded against an instruction-level reference model.
module tb_dec_exe_alu;

    typedef struct packed {
        logic        regdst;
        logic        regwr;
        logic        extop;
        logic        alusrc;
        logic        memwr;
        logic        memtoreg;
        logic        jump;
        logic        branch;
        logic [2:0]  signal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] beq_offset;
        logic [25:0] jump_offset;
        logic [31:0] imm;
        logic [31:0] alu_result;
        logic        zero;
        logic        overflow;
        logic        illegal;
    } obs_t;

    typedef struct {
        int    due;
        obs_t  e;
        string name;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    sb_t  sbq[$];

    dec_exe_alu_if bus ();

    dec_exe_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // True when the exact signed sum/difference does not fit in 32 bits
    function automatic bit sovf(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint s;
        s = sub ? (longint'($signed(a)) - longint'($signed(b)))
                : (longint'($signed(a)) + longint'($signed(b)));
        return s != longint'($signed(s[31:0]));
    endfunction

    // Instruction-level reference: what each MIPS instruction means.
    function automatic obs_t model(input logic r, input logic [31:0] i,
                                   input logic [31:0] a, input logic [31:0] b);
        obs_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] sx;
        logic [31:0] zx;
        bit          ill;
        e = '0;
        if (r) return e;
        op = i[31:26];
        fn = i[5:0];
        sh = i[10:6];
        sx = {{16{i[15]}}, i[15:0]};
        zx = {16'd0, i[15:0]};
        ill = 0;
        e.rs = i[25:21];
        e.rt = i[20:16];
        e.rd = i[15:11];
        e.beq_offset  = i[15:0];
        e.jump_offset = i[25:0];
        case (op)
            6'h00: begin
                e.regdst = 1; e.regwr = 1;
                case (fn)
                    6'h20: begin e.signal = 0; e.alu_result = a + b; e.overflow = sovf(a, b, 0); end
                    6'h21: begin e.signal = 0; e.alu_result = a + b; end
                    6'h22: begin e.signal = 1; e.alu_result = a - b; e.overflow = sovf(a, b, 1); end
                    6'h23: begin e.signal = 1; e.alu_result = a - b; end
                    6'h24: begin e.signal = 2; e.alu_result = a & b; end
                    6'h25: begin e.signal = 3; e.alu_result = a | b; end
                    6'h27: begin e.signal = 7; e.alu_result = ~(a | b); end
                    6'h2A: begin e.signal = 4; e.alu_result = ($signed(a) < $signed(b)) ? 1 : 0; end
                    6'h00: begin e.signal = 5; e.alu_result = b << sh; end
                    6'h02: begin e.signal = 6; e.alu_result = b >> sh; end
                    default: ill = 1;
                endcase
            end
            6'h08: begin e.regwr = 1; e.alusrc = 1; e.extop = 1; e.alu_result = a + sx; e.overflow = sovf(a, sx, 0); end
            6'h0C: begin e.regwr = 1; e.alusrc = 1; e.signal = 2; e.alu_result = a & zx; end
            6'h0D: begin e.regwr = 1; e.alusrc = 1; e.signal = 3; e.alu_result = a | zx; end
            6'h23: begin e.regwr = 1; e.alusrc = 1; e.extop = 1; e.memtoreg = 1; e.alu_result = a + sx; end
            6'h2B: begin e.memwr = 1; e.alusrc = 1; e.extop = 1; e.alu_result = a + sx; end
            6'h04: begin e.branch = 1; e.extop = 1; e.signal = 1; e.alu_result = a - b; e.overflow = sovf(a, b, 1); end
            6'h02: begin e.jump = 1; e.alu_result = a + b; end
            default: ill = 1;
        endcase
        if (ill) begin
            e.regdst = 0; e.regwr = 0; e.extop = 0; e.alusrc = 0; e.memwr = 0;
            e.memtoreg = 0; e.jump = 0; e.branch = 0; e.signal = 0;
            e.alu_result = 0; e.overflow = 0; e.illegal = 1;
        end
        if (e.regwr && ((e.regdst ? e.rd : e.rt) == 5'd0)) e.regwr = 0;
        e.imm  = e.extop ? sx : zx;
        e.zero = (e.alu_result == 32'd0);
        return e;
    endfunction

    task automatic drive(input string name, input logic r, input logic [31:0] i,
                         input logic [31:0] a, input logic [31:0] b);
        sb_t s;
        @(posedge clk);
        #1;
        rst        = r;
        bus.inst   = i;
        bus.rs_val = a;
        bus.rt_val = b;
        s.due  = cyc + 1;
        s.e    = model(r, i, a, b);
        s.name = name;
        sbq.push_back(s);
    endtask

    // Monitor: results become visible the edge after issue; checked mid-cycle
    always @(negedge clk) begin
        obs_t got;
        sb_t  s;
        got = '{bus.regdst, bus.regwr, bus.extop, bus.alusrc, bus.memwr, bus.memtoreg,
                bus.jump, bus.branch, bus.signal, bus.rs, bus.rt, bus.rd, bus.beq_offset,
                bus.jump_offset, bus.imm, bus.alu_result, bus.zero, bus.overflow, bus.illegal};
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            s = sbq.pop_front();
            checks++;
            if (s.due != cyc) begin
                errors++;
                $display("FAIL %s: result slot missed (due cycle %0d, now %0d)", s.name, s.due, cyc);
            end else if (got !== s.e) begin
                errors++;
                $display("FAIL %s: got %h required %h (alu_result got %h req %h)",
                         s.name, got, s.e, got.alu_result, s.e.alu_result);
            end
        end
    end

    logic [5:0]  ops [8]  = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    logic [5:0]  fns [10] = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h5};

    function automatic logic [31:0] rand_val();
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst        = 1'b1;
        bus.inst   = 32'h0;
        bus.rs_val = 32'h0;
        bus.rt_val = 32'h0;

        // Reset wins over a presented instruction
        drive("reset_a", 1, 32'h00221820, 1, 2);
        drive("reset_b", 1, 32'h00221820, 1, 2);

        drive("add_basic", 0, 32'h00221820, 1, 2);
        drive("sub_neg",   0, 32'h00221822, 1, 2);
        drive("and_zero",  0, 32'h00221824, 1, 2);
        drive("add_ovf",   0, 32'h00221820, 32'h7FFFFFFF, 1);
        drive("addu_novf", 0, 32'h00221821, 32'h7FFFFFFF, 1);
        drive("beq_eq",    0, 32'h1022FFFF, 5, 5);
        drive("lw",        0, 32'h8C430004, 8, 0);
        drive("illegal3f", 0, 32'hFC000000, 32'h1234, 32'h5678);
        drive("sll_r0",    0, 32'h00000000, 3, 9);
        drive("sll_sh",    0, 32'h00021900, 0, 32'h80000001);
        drive("srl_sh",    0, 32'h00021F02, 0, 32'h80000000);
        drive("slt_neg",   0, 32'h0022182A, 32'hFFFFFFFF, 1);
        drive("bad_funct", 0, 32'h0022183F, 1, 2);
        drive("andi_zx",   0, 32'h3022FFFF, 32'hFFFFFFFF, 0);
        drive("addi_ovf",  0, 32'h20227FFF, 32'h7FFFFFFF, 0);
        drive("sub_ovf",   0, 32'h00221822, 32'h80000000, 1);
        drive("j",         0, 32'h0BADBEEF, 4, 6);

        // Reset in the middle of an add stream
        drive("stream_0",  0, 32'h00221820, 10, 20);
        drive("stream_rs", 1, 32'h00221820, 11, 21);
        drive("stream_1",  0, 32'h00221820, 12, 22);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 7)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 9) != 0) ins[5:0] = fns[$urandom_range(0, 9)];
            drive("random", ($urandom_range(0, 39) == 0), ins, rand_val(), rand_val());
        end

        // Drain with a bounded wait
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_exe_alu.md
DEC_EXE_ALU -- requirements
Module: dec_exe_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 inst  input  32  MIPS instruction word to decode and execute.
REQ-005 rs_val  input  32  register-file value addressed by inst[25:21].
REQ-006 rt_val  input  32  register-file value addressed by inst[20:16].
REQ-007 regdst, regwr, extop, alusrc, memwr, memtoreg, jump, branch  output  1 each  registered control signals.
REQ-008 signal  output  3  registered ALU operation code.
REQ-009 rs, rt, rd  output  5 each  registered register fields inst[25:21], inst[20:16], inst[15:11].
REQ-010 beq_offset  output  16  inst[15:0]; jump_offset  output  26  inst[25:0]; both registered.
REQ-011 imm  output  32  registered extended immediate.
REQ-012 alu_result  output  32; zero  output  1; overflow  output  1; illegal  output  1; all registered.

Function
REQ-013 All outputs SHALL update on the rising clk edge from the current inst, rs_val and rt_val, giving a latency of one cycle.
REQ-014 Operation codes SHALL be 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 SLL, 110 SRL, 111 NOR.
REQ-015 Opcode 0 (R-type) SHALL produce regdst=1, regwr=1, alusrc=0, extop=0. Funct decoding:
- 0x20 and 0x21 -> ADD
- 0x22 and 0x23 -> SUB
- 0x24 -> AND
- 0x25 -> OR
- 0x27 -> NOR
- 0x2A -> SLT
- 0x00 -> SLL
- 0x02 -> SRL
REQ-016 addi (0x08) SHALL produce regwr=1, alusrc=1, extop=1, ADD.
REQ-017 andi (0x0C) and ori (0x0D) SHALL produce regwr=1, alusrc=1, extop=0, with AND and OR respectively.
REQ-018 lw (0x23) SHALL produce regwr=1, alusrc=1, extop=1, memtoreg=1, ADD.
REQ-019 sw (0x2B) SHALL produce memwr=1, alusrc=1, extop=1, ADD.
REQ-020 beq (0x04) SHALL produce branch=1, extop=1, alusrc=0, SUB.
REQ-021 j (0x02) SHALL produce jump=1 with signal ADD.
REQ-022 Any control not listed in REQ-015 to REQ-021 SHALL be 0.
REQ-023 An unknown opcode, or an unknown funct under opcode 0, SHALL force all controls to 0, set illegal=1, and produce alu_result=0.
REQ-024 Immediate extension SHALL follow extop: imm is sign-extended from inst[15:0] when extop=1 and zero-extended when extop=0.
REQ-025 The ALU B operand SHALL be imm when alusrc=1 and rt_val otherwise; the A operand SHALL be rs_val.
REQ-026 Shift operations SHALL shift the B operand by inst[10:6]; SRL SHALL be a logical shift.
REQ-027 Arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-028 overflow SHALL be 1 only on signed overflow of ADD or SUB when the decoded instruction is add, addi, sub or beq; overflow SHALL be 0 for addu, subu, lw and sw.
REQ-029 zero SHALL be 1 exactly when the 32-bit ALU result equals 0.
REQ-030 regwr SHALL be forced to 0 when the destination register is 0, where the destination is rd if regdst=1 and rt otherwise.

Reset
REQ-031 While rst=1 at a rising clk edge, every output SHALL become 0, including illegal, zero and overflow.
REQ-032 Reset SHALL take priority over a simultaneously presented instruction.
REQ-033 The first non-reset edge after reset SHALL produce the normal result for the inst present at that edge.

Structure
REQ-034 A shared package SHALL hold the opcode and funct constants and the 3-bit ALU-op enumeration.
REQ-035 The block SHALL contain a combinational decoder and exactly one combinational sub-module alu_core, with ports a, b, shamt, op, result, zero, overflow.
REQ-036 All outputs SHALL be driven from registers in the top level.

Verification
REQ-037 rs_val=1, rt_val=2, inst=0x00221820 -> after one edge: alu_result=3, regdst=1, regwr=1, rd=3, zero=0.
REQ-038 The same operands with inst=0x00221822 -> alu_result=0xFFFFFFFF, overflow=0; with inst=0x00221824 -> alu_result=0, zero=1.
REQ-039 rs_val=0x7FFFFFFF, rt_val=1, add -> alu_result=0x80000000, overflow=1; the same operands with addu -> overflow=0.
REQ-040 beq with rs_val=rt_val=5 and offset 0xFFFF -> branch=1, zero=1, imm=0xFFFFFFFF; lw 0x8C430004 with rs_val=8 -> alu_result=12, memtoreg=1, regdst=0.
REQ-041 Illegal opcode 0x3F -> illegal=1 with all controls 0; inst=0x00000000 (sll to register 0) -> regwr=0.
REQ-042 rst asserted for one edge during an add stream -> all outputs 0 on that edge, and the correct result on the next edge.
